int_ctrl: RTL and testbench
===========================

# int_ctrl

Trap/interrupt sequencer for the CPU core, sitting between the decode/execute stages and the CSR file's `int_*` port. On `ecall`, `ebreak`, or an enabled asynchronous interrupt, it stalls the pipeline and writes `mepc`, `mstatus` and `mcause` over successive cycles. It then redirects fetch to `mtvec`. On `mret` it restores `mstatus` and redirects to `mepc`.

## Interface
- `DW`, default 16: data width, equal to `DATABUS`.
- `AW`, default 16: CSR address width, equal to `ADDRBUS`; only bits [11:0] are significant.

- `clk` input, 1: clock.
- `rst_n` input, 1: reset; asynchronous, active-low.
- `inst_addr_i` input, DW: PC of the instruction currently in EX.
- `ecall_i`, `ebreak_i`, `mret_i` input, 1 each: decoded instruction flags for the instruction in EX; one-hot or zero.
- `jump_flag_i` input, 1: EX is taking a branch or jump this cycle.
- `jump_addr_i` input, DW: target of that branch or jump.
- `irq_ext_i`, `irq_tmr_i` input, 1 each: level interrupt requests.
- `ex_csr_we_i` input, 1: EX is writing a CSR this cycle.
- `global_int_en_i` input, 1: `mstatus[3]` from the CSR file.
- `csr_mtvec_i`, `csr_mepc_i`, `csr_mstatus_i` input, DW: CSR file values.
- `int_we_o` output, 1: write strobe to the CSR file.
- `int_waddr_o`, `int_raddr_o` output, AW: CSR write and read addresses.
- `int_wdata_o` output, DW: CSR write data.
- `hold_o` output, 1: pipeline stall request.
- `int_assert_o` output, 1: one-cycle fetch redirect.
- `int_addr_o` output, DW: redirect target.

## Operation
- **States:** IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, ASSERT, MRET.

- **IDLE, trap acceptance:**
  - A trap is accepted only when `ex_csr_we_i` is 0. The EX CSR write has priority inside the CSR file and must not collide with a trap write.
  - Priority: `ecall` > `ebreak` > `irq_ext` > `irq_tmr`.
  - Interrupts are considered only when `global_int_en_i` is 1.
- **IDLE, latching on acceptance:**
  - Latch the cause:
    - `ecall` → 0x000B
    - `ebreak` → 0x0003
    - `irq_ext` → 0x800B
    - `irq_tmr` → 0x8007
  - Latch the return PC:
    - Synchronous exceptions: `inst_addr_i`.
    - Interrupts: `jump_addr_i` if `jump_flag_i` is 1, else `inst_addr_i`.
  - Go to W_MEPC.
- **IDLE, `mret`:** `mret_i` with `ex_csr_we_i` at 0 goes to MRET. A simultaneous interrupt is ignored for that cycle.
- **W_MEPC:** write `mepc` ← latched PC.
- **W_MSTATUS:** write `mstatus` ← `csr_mstatus_i` with bit7 (MPIE) set to old bit3 and bit3 (MIE) cleared. All other bits are unchanged.
- **W_MCAUSE:** write `mcause` ← latched cause.
- **ASSERT:** `int_assert_o`=1 and `int_addr_o`=`csr_mtvec_i`; return to IDLE.
- **MRET:**
  - Write `mstatus` ← `csr_mstatus_i` with bit3 set to old bit7 and bit7 set to 1.
  - Assert `int_assert_o` with `int_addr_o`=`csr_mepc_i` in the same cycle; return to IDLE.
- `int_raddr_o` is constantly `CSR_MSTATUS`.
- Interrupt lines are level-sensitive:
  - Requests seen while busy are not latched; they are re-evaluated on return to IDLE.
  - After entry, MIE=0 blocks re-entry.

## Timing
- **Reset values:** all outputs 0; state IDLE; the cause and PC latches are 0.
- **Reset mid-sequence:** the sequence aborts immediately and the partial CSR writes stand.
- **Trap accepted in cycle T:**
  - `hold_o` is asserted combinationally in T and stays high through T+4.
  - CSR writes occur at the clock edges ending T+1 (mepc), T+2 (mstatus) and T+3 (mcause).
  - `int_assert_o` is high in T+4 only.
  - Total latency from acceptance to redirect is 4 cycles.
- **`mret` accepted in cycle T:** `hold_o` is high in T and T+1; the write and the redirect both happen in T+1.
- `int_we_o` is high only in W_MEPC, W_MSTATUS, W_MCAUSE and MRET; `int_waddr_o` and `int_wdata_o` are 0 otherwise.
- The `mtvec` and `mepc` redirect values are sampled in the redirect cycle, so back-to-back CSR updates are visible.

## Structure
- Shared `para.v` holds:
  - CSR addresses (`CSR_MEPC`, `CSR_MSTATUS`, `CSR_MCAUSE`, …).
  - Cause codes (`CAUSE_ECALL`, `CAUSE_EBREAK`, `CAUSE_IRQ_EXT`, `CAUSE_IRQ_TMR`).
  - mstatus bit indices (`MSTATUS_MIE`=3, `MSTATUS_MPIE`=7).
  - State encodings.
- The priority/cause selection may be a small sub-module `int_prio`; everything else stays flat in `int_ctrl`.

## Test plan
- **ecall:** `ecall_i` at PC 0x0040 with mstatus=0x0008 and mtvec=0x0100.
  - Expect writes mepc=0x0040, mstatus=0x0080, mcause=0x000B.
  - Redirect to 0x0100 in T+4; `hold_o` high for 5 cycles.
- **External interrupt during a jump:** `irq_ext_i` with MIE=1 while `jump_flag_i`=1 and `jump_addr_i`=0x0200 → mepc=0x0200, mcause=0x800B.
- **Masked interrupt:** `irq_tmr_i` with MIE=0 → no `hold_o` and no CSR write. Setting MIE=1 then → mcause=0x8007.
- **Collision:** `ecall_i` and `ex_csr_we_i` both high in one cycle → no entry that cycle; entry the next cycle once `ex_csr_we_i`=0.
- **mret:** with mstatus=0x0080 and mepc=0x0044, `mret_i` → mstatus=0x0088 and redirect to 0x0044 in T+1.
- **Reset in W_MSTATUS:** deassert `rst_n` → outputs 0 immediately; mepc has been written, mcause is untouched.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared CSR addresses, cause codes, mstatus bit indices and sequencer states
package int_ctrl_pkg;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_MEPC = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [3:0] CODE_ECALL = 4'd11;
  localparam logic [3:0] CODE_EBREAK = 4'd3;
  localparam logic [3:0] CODE_IRQ_EXT = 4'd11;
  localparam logic [3:0] CODE_IRQ_TMR = 4'd7;
  localparam int MSTATUS_MIE = 3;
  localparam int MSTATUS_MPIE = 7;
  typedef enum logic [2:0] {
    S_IDLE,
    S_MEPC,
    S_MSTATUS,
    S_MCAUSE,
    S_ASSERT,
    S_MRET
  } state_t;
endpackage

// File: rtl/int_prio.sv
// int_prio: picks the winning trap source (ecall > ebreak > irq_ext > irq_tmr) and its cause code
//   in:  ecall, ebreak, irq_ext, irq_tmr, irq_en (interrupts allowed)
//   out: valid (some source wins), is_int (winner is an interrupt), code (cause low bits)
module int_prio
  import int_ctrl_pkg::*;
(
  input  logic       ecall,
  input  logic       ebreak,
  input  logic       irq_ext,
  input  logic       irq_tmr,
  input  logic       irq_en,
  output logic       valid,
  output logic       is_int,
  output logic [3:0] code
);
  always_comb begin
    valid = ecall | ebreak | (irq_en & (irq_ext | irq_tmr));
    is_int = ~ecall & ~ebreak;
    code = ecall ? CODE_ECALL : ebreak ? CODE_EBREAK : irq_ext ? CODE_IRQ_EXT : CODE_IRQ_TMR;
  end
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: trap/interrupt sequencer writing mepc, mstatus, mcause then redirecting fetch; handles mret
//   in:  pipeline flags/PCs, level irqs, EX CSR-write flag, MIE, mtvec/mepc/mstatus from the CSR file
//   out: CSR write port (we/waddr/wdata), CSR read address, hold, one-cycle redirect (assert/addr)
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] inst_addr_i,
  input  logic          ecall_i,
  input  logic          ebreak_i,
  input  logic          mret_i,
  input  logic          jump_flag_i,
  input  logic [DW-1:0] jump_addr_i,
  input  logic          irq_ext_i,
  input  logic          irq_tmr_i,
  input  logic          ex_csr_we_i,
  input  logic          global_int_en_i,
  input  logic [DW-1:0] csr_mtvec_i,
  input  logic [DW-1:0] csr_mepc_i,
  input  logic [DW-1:0] csr_mstatus_i,
  output logic          int_we_o,
  output logic [AW-1:0] int_waddr_o,
  output logic [AW-1:0] int_raddr_o,
  output logic [DW-1:0] int_wdata_o,
  output logic          hold_o,
  output logic          int_assert_o,
  output logic [DW-1:0] int_addr_o
);
  state_t state;
  logic [DW-1:0] cause, pc, st_trap, st_mret;
  logic idle, valid, is_int, trap_acc, mret_acc;
  logic [3:0] code;
  assign idle = state == S_IDLE;
  // mret wins over a same-cycle interrupt, so interrupts are masked while mret is decoded
  int_prio u_prio (
    .ecall(ecall_i),
    .ebreak(ebreak_i),
    .irq_ext(irq_ext_i),
    .irq_tmr(irq_tmr_i),
    .irq_en(global_int_en_i & ~mret_i),
    .valid(valid),
    .is_int(is_int),
    .code(code)
  );
  // an EX CSR write owns the CSR port this cycle, so nothing is accepted alongside it
  assign trap_acc = idle & ~ex_csr_we_i & valid;
  assign mret_acc = idle & ~ex_csr_we_i & mret_i & ~valid;
  always_comb begin
    st_trap = csr_mstatus_i;
    st_trap[MSTATUS_MPIE] = csr_mstatus_i[MSTATUS_MIE];
    st_trap[MSTATUS_MIE] = 1'b0;
    st_mret = csr_mstatus_i;
    st_mret[MSTATUS_MIE] = csr_mstatus_i[MSTATUS_MPIE];
    st_mret[MSTATUS_MPIE] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cause <= '0;
      pc <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (trap_acc) begin
            state <= S_MEPC;
            cause <= {is_int, {(DW-5){1'b0}}, code};
            // an interrupt taken during a jump must resume at the jump target
            pc <= (is_int & jump_flag_i) ? jump_addr_i : inst_addr_i;
          end else if (mret_acc) begin
            state <= S_MRET;
          end
        end
        S_MEPC: state <= S_MSTATUS;
        S_MSTATUS: state <= S_MCAUSE;
        S_MCAUSE: state <= S_ASSERT;
        S_ASSERT: state <= S_IDLE;
        S_MRET: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
  // redirect and mstatus data are taken live so same-cycle CSR updates are honoured
  always_comb begin
    int_we_o = state inside {S_MEPC, S_MSTATUS, S_MCAUSE, S_MRET};
    int_waddr_o = state == S_MEPC ? AW'(CSR_MEPC) :
                  state == S_MCAUSE ? AW'(CSR_MCAUSE) :
                  (state == S_MSTATUS || state == S_MRET) ? AW'(CSR_MSTATUS) : '0;
    int_wdata_o = state == S_MEPC ? pc :
                  state == S_MSTATUS ? st_trap :
                  state == S_MCAUSE ? cause :
                  state == S_MRET ? st_mret : '0;
    hold_o = rst_n & (~idle | trap_acc | mret_acc);
    int_assert_o = state == S_ASSERT || state == S_MRET;
    int_addr_o = state == S_ASSERT ? csr_mtvec_i : state == S_MRET ? csr_mepc_i : '0;
    int_raddr_o = rst_n ? AW'(CSR_MSTATUS) : '0;
  end
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: table vectors, directed corner sequences and random traffic against a schedule model
module tb_int_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  logic [15:0] inst_addr = '0, jump_addr = '0;
  logic ecall = 0, ebreak = 0, mret = 0, jump_flag = 0, irq_ext = 0, irq_tmr = 0, ex_csr_we = 0;
  logic [15:0] ex_waddr = '0, ex_wdata = '0;
  logic [15:0] mtvec = '0, mepc = '0, mstatus = '0, mcause = '0;
  logic int_we, hold, int_assert;
  logic [15:0] int_waddr, int_raddr, int_wdata, int_addr;
  logic [127:0] obs;
  int n_run = 0, n_fail = 0;

  int_ctrl #(.DW(16), .AW(16)) dut (
    .clk(clk), .rst_n(rst_n), .inst_addr_i(inst_addr), .ecall_i(ecall), .ebreak_i(ebreak),
    .mret_i(mret), .jump_flag_i(jump_flag), .jump_addr_i(jump_addr), .irq_ext_i(irq_ext),
    .irq_tmr_i(irq_tmr), .ex_csr_we_i(ex_csr_we), .global_int_en_i(mstatus[3]),
    .csr_mtvec_i(mtvec), .csr_mepc_i(mepc), .csr_mstatus_i(mstatus), .int_we_o(int_we),
    .int_waddr_o(int_waddr), .int_raddr_o(int_raddr), .int_wdata_o(int_wdata), .hold_o(hold),
    .int_assert_o(int_assert), .int_addr_o(int_addr)
  );

  assign obs = 128'({int_raddr, int_we, int_waddr, int_wdata, hold, int_assert, int_addr});

  // CSR file stand-in: EX writes take priority over sequencer writes; not cleared by reset
  always @(posedge clk) begin
    if (ex_csr_we)
      case (ex_waddr[11:0])
        12'h300: mstatus <= ex_wdata;
        12'h305: mtvec <= ex_wdata;
        12'h341: mepc <= ex_wdata;
        12'h342: mcause <= ex_wdata;
        default: ;
      endcase
    else if (int_we)
      case (int_waddr[11:0])
        12'h300: mstatus <= int_wdata;
        12'h305: mtvec <= int_wdata;
        12'h341: mepc <= int_wdata;
        12'h342: mcause <= int_wdata;
        default: ;
      endcase
  end

  function automatic logic [127:0] pk(input logic we, input logic [15:0] wa, input logic [15:0] wd,
                                      input logic h, input logic as, input logic [15:0] ad);
    return 128'({16'h0300, we, wa, wd, h, as, ad});
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    ecall = 0; ebreak = 0; mret = 0; irq_ext = 0; irq_tmr = 0; jump_flag = 0;
    ex_csr_we = 0; ex_waddr = '0;
  endtask

  task automatic ex_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    ex_csr_we = 1; ex_waddr = a; ex_wdata = d;
    @(negedge clk);
    ex_csr_we = 0; ex_waddr = '0;
  endtask

  typedef struct {
    logic ecall, ebreak, mret, ext, tmr, exwe, mie, jf;
    logic [15:0] inst, ja;
    logic hold;
    logic [15:0] cause, pc;
  } vec_t;
  vec_t tv[9];

  typedef enum int {ST_MEPC, ST_MSTAT, ST_MCAUSE, ST_ASRT, ST_MRET} step_e;
  step_e q[$];
  step_e s;
  logic [15:0] m_pc, m_cause, e_wa, e_wd, e_ad;
  logic e_we, e_h, e_as;
  int r;

  initial begin
    // ecall ebreak mret ext tmr exwe mie jf inst ja hold cause pc  (cause FFFF marks mret)
    tv[0] = '{1,0,0,0,0,0,1,0,16'h0040,16'h0000,1,16'h000B,16'h0040};
    tv[1] = '{0,1,0,1,0,0,1,0,16'h0050,16'h0000,1,16'h0003,16'h0050};
    tv[2] = '{0,0,0,1,1,0,1,1,16'h0060,16'h0200,1,16'h800B,16'h0200};
    tv[3] = '{0,0,0,0,1,0,1,0,16'h0066,16'h0300,1,16'h8007,16'h0066};
    tv[4] = '{0,0,0,0,1,0,0,0,16'h0070,16'h0000,0,16'h0000,16'h0000};
    tv[5] = '{1,0,0,0,0,1,1,0,16'h0074,16'h0000,0,16'h0000,16'h0000};
    tv[6] = '{0,0,1,1,0,0,1,0,16'h0078,16'h0000,1,16'hFFFF,16'h0000};
    tv[7] = '{1,0,0,0,1,0,1,1,16'h007C,16'h0400,1,16'h000B,16'h007C};
    tv[8] = '{0,0,0,1,0,0,0,0,16'h0080,16'h0000,0,16'h0000,16'h0000};

    #1 rst_n = 0;
    #2 chk("reset_outputs", obs, 128'(0));
    @(negedge clk); rst_n = 1;
    #1 chk("idle_after_reset", obs, pk(0, 0, 0, 0, 0, 0));

    // ecall full sequence
    ex_write(16'h0300, 16'h0008);
    ex_write(16'h0305, 16'h0100);
    inst_addr = 16'h0040; ecall = 1;
    #1 chk("ecall_T", obs, pk(0, 0, 0, 1, 0, 0));
    @(negedge clk); ecall = 0;
    #1 chk("ecall_mepc", obs, pk(1, 16'h0341, 16'h0040, 1, 0, 0));
    @(negedge clk);
    #1 chk("ecall_mstatus", obs, pk(1, 16'h0300, 16'h0080, 1, 0, 0));
    @(negedge clk);
    #1 chk("ecall_mcause", obs, pk(1, 16'h0342, 16'h000B, 1, 0, 0));
    @(negedge clk);
    #1 chk("ecall_assert", obs, pk(0, 0, 0, 1, 1, 16'h0100));
    @(negedge clk);
    #1 chk("ecall_done", obs, pk(0, 0, 0, 0, 0, 0));
    chk("ecall_csrs", 128'({mepc, mstatus, mcause}), 128'({16'h0040, 16'h0080, 16'h000B}));

    // collision with an EX CSR write defers entry by one cycle
    ecall = 1; ex_csr_we = 1; ex_waddr = '0;
    #1 chk("collide_blocked", obs, pk(0, 0, 0, 0, 0, 0));
    @(negedge clk); ex_csr_we = 0;
    #1 chk("collide_accept", obs, pk(0, 0, 0, 1, 0, 0));
    @(negedge clk); ecall = 0;
    #1 chk("collide_mepc", obs, pk(1, 16'h0341, 16'h0040, 1, 0, 0));
    repeat (4) @(negedge clk);

    // mret
    ex_write(16'h0300, 16'h0080);
    ex_write(16'h0341, 16'h0044);
    mret = 1;
    #1 chk("mret_T", obs, pk(0, 0, 0, 1, 0, 0));
    @(negedge clk); mret = 0;
    #1 chk("mret_T1", obs, pk(1, 16'h0300, 16'h0088, 1, 1, 16'h0044));
    @(negedge clk);
    #1 chk("mret_done", obs, pk(0, 0, 0, 0, 0, 0));
    chk("mret_mstatus", 128'(mstatus), 128'(16'h0088));

    // masked timer, then enabled, then re-entry blocked by cleared MIE
    ex_write(16'h0300, 16'h0000);
    inst_addr = 16'h0050; irq_tmr = 1;
    #1 chk("tmr_masked0", obs, pk(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    #1 chk("tmr_masked1", obs, pk(0, 0, 0, 0, 0, 0));
    ex_write(16'h0300, 16'h0008);
    #1 chk("tmr_accept", obs, pk(0, 0, 0, 1, 0, 0));
    repeat (5) @(negedge clk);
    #1 chk("tmr_no_reentry", obs, pk(0, 0, 0, 0, 0, 0));
    irq_tmr = 0;
    chk("tmr_csrs", 128'({mepc, mcause}), 128'({16'h0050, 16'h8007}));

    // reset while writing mstatus
    ex_write(16'h0342, 16'h0000);
    ex_write(16'h0341, 16'h0000);
    ex_write(16'h0300, 16'h0008);
    inst_addr = 16'h0080; ecall = 1;
    @(negedge clk); ecall = 0;
    @(negedge clk);
    #1 rst_n = 0;
    #1 chk("rst_mid_outputs", obs, 128'(0));
    @(negedge clk);
    chk("rst_mid_csrs", 128'({mepc, mstatus, mcause}), 128'({16'h0080, 16'h0008, 16'h0000}));
    rst_n = 1;
    #1 chk("rst_mid_idle", obs, pk(0, 0, 0, 0, 0, 0));

    // table of single-cycle acceptance decisions
    for (int i = 0; i < 9; i++) begin
      ex_write(16'h0341, 16'h0044);
      ex_write(16'h0300, tv[i].mie ? 16'h0008 : 16'h0000);
      ecall = tv[i].ecall; ebreak = tv[i].ebreak; mret = tv[i].mret;
      irq_ext = tv[i].ext; irq_tmr = tv[i].tmr; ex_csr_we = tv[i].exwe; ex_waddr = '0;
      jump_flag = tv[i].jf; inst_addr = tv[i].inst; jump_addr = tv[i].ja;
      #1 chk($sformatf("tv%0d_hold", i), 128'(hold), 128'(tv[i].hold));
      @(negedge clk); clr();
      #1;
      if (tv[i].cause == 16'hFFFF)
        chk($sformatf("tv%0d_mret", i), 128'({int_we, int_assert, int_addr}), 128'({2'b11, 16'h0044}));
      else if (tv[i].hold) begin
        chk($sformatf("tv%0d_pc", i), 128'({int_we, int_waddr, int_wdata}), 128'({1'b1, 16'h0341, tv[i].pc}));
        repeat (2) @(negedge clk);
        #1 chk($sformatf("tv%0d_cause", i), 128'({int_we, int_waddr, int_wdata}), 128'({1'b1, 16'h0342, tv[i].cause}));
        @(negedge clk);
      end else
        chk($sformatf("tv%0d_none", i), 128'({hold, int_we}), 128'(0));
    end
    clr();
    repeat (2) @(negedge clk);

    // random traffic against a schedule-of-steps model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r = int'($urandom % 16);
      ecall = r == 0; ebreak = r == 1; mret = r == 2;
      irq_ext = $urandom % 4 == 0; irq_tmr = $urandom % 4 == 0;
      jump_flag = $urandom % 2 == 0;
      inst_addr = 16'($urandom); jump_addr = 16'($urandom);
      ex_csr_we = 0; ex_waddr = '0;
      if (q.size() == 0 && $urandom % 5 == 0) begin
        ex_csr_we = 1;
        r = int'($urandom % 4);
        ex_waddr = r == 0 ? 16'h0300 : r == 1 ? 16'h0305 : r == 2 ? 16'h0341 : 16'h0342;
        ex_wdata = 16'($urandom);
      end
      #1;
      e_we = 0; e_wa = '0; e_wd = '0; e_h = 0; e_as = 0; e_ad = '0;
      if (q.size() != 0) begin
        s = q.pop_front();
        e_h = 1;
        case (s)
          ST_MEPC: begin e_we = 1; e_wa = 16'h0341; e_wd = m_pc; end
          ST_MSTAT: begin e_we = 1; e_wa = 16'h0300; e_wd = (mstatus & ~16'h0088) | (16'(mstatus[3]) << 7); end
          ST_MCAUSE: begin e_we = 1; e_wa = 16'h0342; e_wd = m_cause; end
          ST_ASRT: begin e_as = 1; e_ad = mtvec; end
          default: begin
            e_we = 1; e_wa = 16'h0300; e_wd = (mstatus & ~16'h0008) | 16'h0080 | (16'(mstatus[7]) << 3);
            e_as = 1; e_ad = mepc;
          end
        endcase
      end else if (!ex_csr_we) begin
        if (ecall || ebreak || (!mret && mstatus[3] && (irq_ext || irq_tmr))) begin
          m_cause = ecall ? 16'h000B : ebreak ? 16'h0003 : irq_ext ? 16'h800B : 16'h8007;
          m_pc = (!ecall && !ebreak && jump_flag) ? jump_addr : inst_addr;
          q.push_back(ST_MEPC); q.push_back(ST_MSTAT); q.push_back(ST_MCAUSE); q.push_back(ST_ASRT);
          e_h = 1;
        end else if (mret) begin
          q.push_back(ST_MRET);
          e_h = 1;
        end
      end
      chk("random", obs, pk(e_we, e_wa, e_wd, e_h, e_as, e_ad));
    end
    clr();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
